// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between two masters, the arbiter and a single memory slave.
//   m0_* / m1_* : master request (req/we/addr/wdata) and ack back
//   m_rdata_o / m_err_o : shared response, valid only with an ack
//   s_*         : slave access strobe, write enable, address, data, ack, rdata
//   hold_flag_o : CPU (m1) stall
// Modports:
//   slave  - the arbiter's view (it serves the masters' requests)
//   master - the environment's view (masters plus the memory model)
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic              m0_ack_o;
  logic              m1_ack_o;
  logic [DATA_W-1:0] m_rdata_o;
  logic              m_err_o;
  logic              s_req_o;
  logic              s_we_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_wdata_o;
  logic              s_ack_i;
  logic [DATA_W-1:0] s_rdata_i;
  logic              hold_flag_o;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m0_ack_o, m1_ack_o, m_rdata_o, m_err_o,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o,
    input  s_ack_i, s_rdata_i,
    output hold_flag_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m0_ack_o, m1_ack_o, m_rdata_o, m_err_o,
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o,
    output s_ack_i, s_rdata_i,
    input  hold_flag_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of one memory slave, with a slave
// wait timeout that returns an error response.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mem_bus_arbiter_if.slave (master requests/acks, slave access, hold)
// The interface instance must be built with the same ADDR_W/DATA_W.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.slave  bus
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;  // 0 = m0, 1 = m1
  logic              last_q,  last_d;
  req_t              req_q,   req_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q,   err_d;
  logic              win;

  // m1 wins when it is alone, or on a tie when m0 was granted last.
  assign win = bus.m1_req_i & (~bus.m0_req_i | ~last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;  // pretend m1 went last so m0 takes the first tie
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_req_i || bus.m1_req_i) begin
          state_d = ACCESS;
          grant_d = win;
          last_d  = win;
          cnt_d   = '0;
          req_d   = win ? '{bus.m1_we_i, bus.m1_addr_i, bus.m1_wdata_i}
                        : '{bus.m0_we_i, bus.m0_addr_i, bus.m0_wdata_i};
        end
      end
      ACCESS: begin
        // A slave ack on the timeout cycle still counts as a good response.
        if (bus.s_ack_i) begin
          state_d = RESP;
          rdata_d = bus.s_rdata_i;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // s_we/addr/wdata keep the last access after it completes; they only
  // matter while s_req_o is high.
  assign bus.s_req_o     = (state_q == ACCESS);
  assign bus.s_we_o      = req_q.we;
  assign bus.s_addr_o    = req_q.addr;
  assign bus.s_wdata_o   = req_q.wdata;
  assign bus.m0_ack_o    = (state_q == RESP) & ~grant_q;
  assign bus.m1_ack_o    = (state_q == RESP) &  grant_q;
  assign bus.m_rdata_o   = (state_q == RESP) ? rdata_q : '0;
  assign bus.m_err_o     = (state_q == RESP) & err_q;
  assign bus.hold_flag_o = bus.m1_req_i & ~bus.m1_ack_o;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata;
    logic        s_ack;
    logic [31:0] s_rdata;
  } in_t;

  typedef struct packed {
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] rdata;
    logic        err, hold;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic in_t mk_in(logic m0r, logic m0w, logic [31:0] m0a, logic [31:0] m0d,
                                logic m1r, logic m1w, logic [31:0] m1a, logic [31:0] m1d,
                                logic sa, logic [31:0] sd);
    in_t v;
    v = '{m0r, m0w, m0a, m0d, m1r, m1w, m1a, m1d, sa, sd};
    return v;
  endfunction

  function automatic out_t mk_out(logic sreq, logic swe, logic [31:0] sad, logic [31:0] swd,
                                  logic a0, logic a1, logic [31:0] rd, logic er, logic hd);
    out_t v;
    v = '{sreq, swe, sad, swd, a0, a1, rd, er, hd};
    return v;
  endfunction

  function automatic out_t get_out();
    out_t v;
    v = '{bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o, bus.m0_ack_o,
          bus.m1_ack_o, bus.m_rdata_o, bus.m_err_o, bus.hold_flag_o};
    return v;
  endfunction

  task automatic apply(input in_t v);
    bus.m0_req_i = v.m0_req;  bus.m0_we_i = v.m0_we;
    bus.m0_addr_i = v.m0_addr; bus.m0_wdata_i = v.m0_wdata;
    bus.m1_req_i = v.m1_req;  bus.m1_we_i = v.m1_we;
    bus.m1_addr_i = v.m1_addr; bus.m1_wdata_i = v.m1_wdata;
    bus.s_ack_i = v.s_ack;    bus.s_rdata_i = v.s_rdata;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inputs change 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] WD = 32'h1234_5678;

  vec_t tbl[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   first, ack_c, sreq_n;
    logic [31:0] rd;
    logic er;
    int   acks[$];

    tbl[0]  = '{"idle",       mk_in(0,0,0,0, 0,0,0,0, 0,0),                        mk_out(0,0,0,0, 0,0,0,0,0)};
    tbl[1]  = '{"tie_req",    mk_in(1,0,32'h40,0, 1,0,32'h100,0, 0,0),             mk_out(0,0,0,0, 0,0,0,0,1)};
    tbl[2]  = '{"tie_m0_acc", mk_in(1,0,32'h40,0, 1,0,32'h100,0, 1,32'h1111_1111), mk_out(1,0,32'h40,0, 0,0,0,0,1)};
    tbl[3]  = '{"tie_m0_ack", mk_in(1,0,32'h40,0, 1,0,32'h100,0, 0,0),             mk_out(0,0,32'h40,0, 1,0,32'h1111_1111,0,1)};
    tbl[4]  = '{"rr_req",     mk_in(1,1,32'h8,WD, 1,0,32'h100,0, 0,0),             mk_out(0,0,32'h40,0, 0,0,0,0,1)};
    tbl[5]  = '{"rr_m1_acc",  mk_in(1,1,32'h8,WD, 1,0,32'h100,0, 1,32'h2222_2222), mk_out(1,0,32'h100,0, 0,0,0,0,1)};
    tbl[6]  = '{"rr_m1_ack",  mk_in(1,1,32'h8,WD, 1,0,32'h100,0, 0,0),             mk_out(0,0,32'h100,0, 0,1,32'h2222_2222,0,0)};
    tbl[7]  = '{"rr2_req",    mk_in(1,1,32'h8,WD, 1,0,32'h100,0, 0,0),             mk_out(0,0,32'h100,0, 0,0,0,0,1)};
    tbl[8]  = '{"wr_wait",    mk_in(1,1,32'h8,WD, 1,0,32'h100,0, 0,0),             mk_out(1,1,32'h8,WD, 0,0,0,0,1)};
    tbl[9]  = '{"wr_sack",    mk_in(1,1,32'h8,WD, 1,0,32'h100,0, 1,0),             mk_out(1,1,32'h8,WD, 0,0,0,0,1)};
    tbl[10] = '{"wr_ack",     mk_in(1,1,32'h8,WD, 1,0,32'h100,0, 0,0),             mk_out(0,1,32'h8,WD, 1,0,0,0,1)};
    tbl[11] = '{"rd_req",     mk_in(0,0,0,0, 1,0,32'h100,0, 0,0),                  mk_out(0,1,32'h8,WD, 0,0,0,0,1)};
    tbl[12] = '{"rd_sack",    mk_in(0,0,0,0, 1,0,32'h100,0, 1,32'hDEAD_BEEF),      mk_out(1,0,32'h100,0, 0,0,0,0,1)};
    tbl[13] = '{"rd_ack",     mk_in(0,0,0,0, 1,0,32'h100,0, 0,0),                  mk_out(0,0,32'h100,0, 0,1,32'hDEAD_BEEF,0,0)};
    tbl[14] = '{"stray_sack", mk_in(0,0,0,0, 0,0,0,0, 1,32'hBAD),                  mk_out(0,0,32'h100,0, 0,0,0,0,0)};
    tbl[15] = '{"quiet",      mk_in(0,0,0,0, 0,0,0,0, 0,0),                        mk_out(0,0,32'h100,0, 0,0,0,0,0)};

    apply(mk_in(0,0,0,0, 0,0,0,0, 0,0));
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    foreach (tbl[k]) begin
      apply(tbl[k].i);
      #1;
      chk(tbl[k].name, get_out(), tbl[k].o);
      step();
    end

    // timeout: slave never answers m0
    apply(mk_in(1,0,32'h300,0, 0,0,0,0, 0,0));
    first = -1; ack_c = -1; sreq_n = 0; rd = '1; er = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.s_req_o) begin
        sreq_n++;
        if (first < 0) first = c;
      end
      if (bus.m0_ack_o) begin
        ack_c = c; rd = bus.m_rdata_o; er = bus.m_err_o;
        break;
      end
      step();
    end
    chk("to_ack_seen", ack_c >= 0, 1);
    // 16 ACCESS cycles, ack in the 17th cycle counted from the s_req_o rise
    chk("to_sreq_cycles", sreq_n, 16);
    chk("to_latency", ack_c - first, 16);
    chk("to_err", er, 1);
    chk("to_rdata", rd, 0);
    bus.m0_req_i = 1'b0;
    step();

    // slave ack on the very last ACCESS cycle beats the timeout
    apply(mk_in(0,0,0,0, 1,0,32'h204,0, 0,0));
    step();
    #1;
    chk("co_sreq", bus.s_req_o, 1);
    for (int c = 0; c < 16; c++) begin
      bus.s_ack_i   = (c == 15);
      bus.s_rdata_i = 32'hCAFE_F00D;
      step();
    end
    bus.s_ack_i = 1'b0;
    #1;
    chk("co_ack", bus.m1_ack_o, 1);
    chk("co_err", bus.m_err_o, 0);
    chk("co_rdata", bus.m_rdata_o, 32'hCAFE_F00D);
    bus.m1_req_i = 1'b0;
    step();

    // reset in the middle of an m0 access
    apply(mk_in(1,0,32'h500,0, 0,0,0,0, 0,0));
    step();
    #1;
    chk("rst_pre_sreq", bus.s_req_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    apply(mk_in(0,0,0,0, 0,0,0,0, 1,32'hBAD));
    #1;
    chk("rst_outputs", get_out(), mk_out(0,0,0,0, 0,0,0,0,0));
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      chk("rst_no_ack", {bus.m0_ack_o, bus.m1_ack_o, bus.s_req_o}, 0);
    end
    apply(mk_in(1,0,32'h60,0, 1,0,32'h70,0, 0,0));
    step();
    #1;
    chk("rst_tie_m0", bus.s_addr_o, 32'h60);
    bus.s_ack_i = 1'b1;
    step();
    #1;
    chk("rst_tie_ack", {bus.m0_ack_o, bus.m1_ack_o}, 2'b10);

    // back-to-back m1 reads with a slave that acks immediately
    apply(mk_in(0,0,0,0, 1,0,32'h80,0, 1,32'h55));
    for (int c = 0; c < 12; c++) begin
      if (bus.m1_ack_o) acks.push_back(c);
      @(posedge clk);
      #2;
    end
    chk("b2b_count", acks.size(), 3);
    if (acks.size() >= 3) begin
      chk("b2b_gap1", acks[1] - acks[0], 3);
      chk("b2b_gap2", acks[2] - acks[1], 3);
    end
    apply(mk_in(0,0,0,0, 0,0,0,0, 0,0));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
